uart_tx_engine: RTL and testbench
=================================

# uart_tx_engine

Serial transmit engine that sits directly downstream of the packetizer FSM. It accepts one byte per start pulse and serialises it onto the UART line as a start bit, 8 data bits (LSB first), optional parity and 1 or 2 stop bits. It reports readiness and frame completion back to the packetizer, which uses them to pace FIFO reads.

## Interface
- CLKS_PER_BIT, 868: clock cycles per bit period (100 MHz / 115200). Legal range ≥ 2.
- PARITY_EN, 0: 1 inserts a parity bit after the data bits.
- PARITY_ODD, 0: parity sense when PARITY_EN=1. 0 = even, 1 = odd.
- STOP_BITS, 1: number of stop bits, 1 or 2.

- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start_tx  input  1  request to send data_in. Single-cycle pulse from the packetizer.
- data_in  input  8  byte to send. Valid only in the cycle start_tx=1.
- tx_ready  output  1  engine idle; a start in this cycle will be accepted.
- tx_done  output  1  one-cycle pulse when the final stop bit completes.
- tx_active  output  1  a frame is in progress (start bit through last stop bit).
- tx_serial  output  1  UART line. Registered output, idles high.

## Operation
- States are IDLE, START, DATA, PARITY, STOP. Every non-IDLE state lasts CLKS_PER_BIT cycles per bit, counted by baud_cnt (width clog2(CLKS_PER_BIT)). baud_cnt resets to 0 on each state or bit change.
- IDLE: tx_serial=1, tx_ready=1.
  - If start_tx=1, latch data_in into shift_reg, compute the parity bit from data_in, and go to START.
  - start_tx while not in IDLE is ignored. There is no queueing, and shift_reg is not overwritten.
- START: tx_serial=0 for CLKS_PER_BIT cycles, then go to DATA with bit_idx=0.
- DATA: tx_serial=shift_reg[bit_idx].
  - bit_idx increments after each bit period.
  - After bit 7, go to PARITY if PARITY_EN=1, otherwise go to STOP.
- PARITY: tx_serial = (^data) XOR PARITY_ODD for one bit period, then go to STOP.
- STOP: tx_serial=1 for STOP_BITS bit periods, then go to IDLE and assert tx_done for one cycle.
- tx_active=1 in START, DATA, PARITY and STOP.
- tx_ready = (state==IDLE). It is registered together with the state.
- Changes to data_in after acceptance have no effect on the frame in progress.
- Reset values: tx_serial=1, tx_ready=1, tx_done=0, tx_active=0, state=IDLE, counters=0, shift_reg=0.
- Reset mid-frame: the line returns high immediately (asynchronously) and no tx_done is issued.

## Timing
- Frame length F = 1 + 8 + PARITY_EN + STOP_BITS bits. Let C = CLKS_PER_BIT. Cycle 0 is the cycle in which start_tx=1 and tx_ready=1.
- tx_ready and tx_active change from cycle 1.
- Start bit: tx_serial=0 in cycles 1..C.
- Data bit i: cycles (i+1)·C+1 .. (i+2)·C.
- Parity bit (if enabled): cycles 9C+1 .. 10C.
- Stop bits occupy the last STOP_BITS·C cycles, ending at cycle F·C.
- Cycle F·C+1: tx_done=1, tx_ready=1, tx_active=0, tx_serial=1.
  - A start_tx in this same cycle is accepted. Its start bit begins in cycle F·C+2.
  - Minimum inter-frame idle is therefore 1 cycle.
- Latency from accepted start to first line transition is 1 cycle. All outputs are registered, with no combinational path from inputs to outputs.
- start_tx and tx_done in the same cycle is legal. The done pulse belongs to the previous frame.

## Test plan
- Reset and idle: assert rst_n=0 for 3 cycles, then release. Required: tx_serial=1, tx_ready=1, tx_done=0, tx_active=0, and these hold with no start.
- Basic frame (C=4, no parity, 1 stop): start_tx with data_in=8'hA5 at cycle 0. Required: line sequence 0,1,0,1,0,0,1,0,1,1 with each bit 4 cycles wide; tx_done pulse exactly at cycle 41; tx_ready low in cycles 1..40.
- Parity (C=4, PARITY_EN=1): send 8'h07. Required: even parity bit = 1. With PARITY_ODD=1, required parity bit = 0. tx_done at cycle 45 in both cases.
- Ignored start (C=4): start 8'h3C at cycle 0, then start_tx with 8'hFF at cycle 10. Required: the transmitted data is still 8'h3C and exactly one tx_done pulse occurs.
- Back-to-back (C=4, STOP_BITS=2): start 8'h55, then start 8'hAA in the tx_done cycle (cycle 45). Required: the second start bit begins at cycle 46 and both frames decode correctly.
- Reset mid-frame (C=4): drop rst_n at cycle 15 during the data bits. Required: tx_serial=1 asynchronously, tx_ready=1, no tx_done, and a fresh 8'h81 after release transmits correctly.

Source files
------------

// File: rtl/uart_tx_engine.sv
// UART transmit engine: start bit, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
// All outputs are registered; tx_ready/tx_active/tx_done move with the state register.
module uart_tx_engine #(
  parameter int CLKS_PER_BIT = 868,
  parameter bit PARITY_EN    = 1'b0,
  parameter bit PARITY_ODD   = 1'b0,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_tx,
  input  logic [7:0] data_in,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_active,
  output logic       tx_serial
);

  localparam int              CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift_reg;
  logic             parity_bit;
  logic             bit_end;

  assign bit_end = (baud_cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      baud_cnt   <= '0;
      bit_idx    <= '0;
      shift_reg  <= '0;
      parity_bit <= 1'b0;
      tx_serial  <= 1'b1;
      tx_ready   <= 1'b1;
      tx_done    <= 1'b0;
      tx_active  <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_tx) begin
            shift_reg  <= data_in;
            parity_bit <= (^data_in) ^ PARITY_ODD;
            baud_cnt   <= '0;
            bit_idx    <= '0;
            state      <= S_START;
            tx_serial  <= 1'b0;
            tx_ready   <= 1'b0;
            tx_active  <= 1'b1;
          end
        end
        S_START: begin
          if (bit_end) begin
            baud_cnt  <= '0;
            bit_idx   <= '0;
            state     <= S_DATA;
            tx_serial <= shift_reg[0];
          end else begin
            baud_cnt <= baud_cnt + CNT_ONE;
          end
        end
        S_DATA: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              bit_idx <= '0;
              if (PARITY_EN) begin
                state     <= S_PARITY;
                tx_serial <= parity_bit;
              end else begin
                state     <= S_STOP;
                tx_serial <= 1'b1;
              end
            end else begin
              bit_idx   <= bit_idx + 3'd1;
              tx_serial <= shift_reg[bit_idx + 3'd1];
            end
          end else begin
            baud_cnt <= baud_cnt + CNT_ONE;
          end
        end
        S_PARITY: begin
          if (bit_end) begin
            baud_cnt  <= '0;
            bit_idx   <= '0;
            state     <= S_STOP;
            tx_serial <= 1'b1;
          end else begin
            baud_cnt <= baud_cnt + CNT_ONE;
          end
        end
        S_STOP: begin
          if (bit_end) begin
            baud_cnt <= '0;
            // bit_idx doubles as the stop-bit counter
            if (bit_idx == STOP_LAST) begin
              bit_idx   <= '0;
              state     <= S_IDLE;
              tx_done   <= 1'b1;
              tx_ready  <= 1'b1;
              tx_active <= 1'b0;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            baud_cnt <= baud_cnt + CNT_ONE;
          end
        end
        default: begin
          state     <= S_IDLE;
          baud_cnt  <= '0;
          bit_idx   <= '0;
          tx_serial <= 1'b1;
          tx_ready  <= 1'b1;
          tx_active <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_engine.sv
// Directed bench for uart_tx_engine: four instances (basic, even parity, odd parity, two stop bits),
// every output compared cycle by cycle against hand-derived frame timing.
module tb_uart_tx_engine;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_tx [4];
  logic [7:0] data_in  [4];
  logic       tx_ready [4];
  logic       tx_done  [4];
  logic       tx_active[4];
  logic       tx_serial[4];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  uart_tx_engine #(.CLKS_PER_BIT(4), .PARITY_EN(1'b0), .PARITY_ODD(1'b0), .STOP_BITS(1)) u_base (
    .clk(clk), .rst_n(rst_n), .start_tx(start_tx[0]), .data_in(data_in[0]),
    .tx_ready(tx_ready[0]), .tx_done(tx_done[0]), .tx_active(tx_active[0]), .tx_serial(tx_serial[0]));
  uart_tx_engine #(.CLKS_PER_BIT(4), .PARITY_EN(1'b1), .PARITY_ODD(1'b0), .STOP_BITS(1)) u_even (
    .clk(clk), .rst_n(rst_n), .start_tx(start_tx[1]), .data_in(data_in[1]),
    .tx_ready(tx_ready[1]), .tx_done(tx_done[1]), .tx_active(tx_active[1]), .tx_serial(tx_serial[1]));
  uart_tx_engine #(.CLKS_PER_BIT(4), .PARITY_EN(1'b1), .PARITY_ODD(1'b1), .STOP_BITS(1)) u_odd (
    .clk(clk), .rst_n(rst_n), .start_tx(start_tx[2]), .data_in(data_in[2]),
    .tx_ready(tx_ready[2]), .tx_done(tx_done[2]), .tx_active(tx_active[2]), .tx_serial(tx_serial[2]));
  uart_tx_engine #(.CLKS_PER_BIT(4), .PARITY_EN(1'b0), .PARITY_ODD(1'b0), .STOP_BITS(2)) u_stop2 (
    .clk(clk), .rst_n(rst_n), .start_tx(start_tx[3]), .data_in(data_in[3]),
    .tx_ready(tx_ready[3]), .tx_done(tx_done[3]), .tx_active(tx_active[3]), .tx_serial(tx_serial[3]));

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input int sel, input string tag);
    chk($sformatf("%s u%0d serial", tag, sel), tx_serial[sel], 1'b1);
    chk($sformatf("%s u%0d ready", tag, sel), tx_ready[sel], 1'b1);
    chk($sformatf("%s u%0d done", tag, sel), tx_done[sel], 1'b0);
    chk($sformatf("%s u%0d active", tag, sel), tx_active[sel], 1'b0);
  endtask

  // Cycle 0 is the cycle start_tx is presented; outputs for cycle k are sampled at its falling edge.
  task automatic run_frame(input int sel, input logic [7:0] d, input int pe, input logic par,
                           input int sb, input bit prestarted, input int inj_cycle,
                           input logic [7:0] inj_data);
    int   last;
    int   b;
    logic exp_bit;
    last = (9 + pe + sb) * 4 + 1;
    if (!prestarted) begin
      @(negedge clk);
      start_tx[sel] = 1'b1;
      data_in[sel]  = d;
      chk($sformatf("u%0d ready c0", sel), tx_ready[sel], 1'b1);
    end
    for (int k = 1; k <= last; k++) begin
      @(negedge clk);
      start_tx[sel] = 1'b0;
      data_in[sel]  = ~d;
      if (k == inj_cycle) begin
        start_tx[sel] = 1'b1;
        data_in[sel]  = inj_data;
      end
      b = (k - 1) / 4;
      if (b == 0)                  exp_bit = 1'b0;
      else if (b <= 8)             exp_bit = d[b-1];
      else if (b == 9 && pe == 1)  exp_bit = par;
      else                         exp_bit = 1'b1;
      chk($sformatf("u%0d serial c%0d", sel, k), tx_serial[sel], exp_bit);
      chk($sformatf("u%0d ready c%0d", sel, k), tx_ready[sel], k == last);
      chk($sformatf("u%0d active c%0d", sel, k), tx_active[sel], k != last);
      chk($sformatf("u%0d done c%0d", sel, k), tx_done[sel], k == last);
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      start_tx[i] = 1'b0;
      data_in[i]  = 8'h00;
    end

    // reset and idle
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) chk_idle(i, "in_reset");
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) chk_idle(i, "idle");
    end

    // basic frame A5: line 0,1,0,1,0,0,1,0,1,1, done at cycle 41
    run_frame(0, 8'hA5, 0, 1'b0, 1, 1'b0, -1, 8'h00);

    // parity on 07: even -> 1, odd -> 0, done at cycle 45
    run_frame(1, 8'h07, 1, 1'b1, 1, 1'b0, -1, 8'h00);
    run_frame(2, 8'h07, 1, 1'b0, 1, 1'b0, -1, 8'h00);

    // start during a frame is ignored
    run_frame(0, 8'h3C, 0, 1'b0, 1, 1'b0, 10, 8'hFF);
    repeat (6) begin
      @(negedge clk);
      chk_idle(0, "after_ignored");
    end

    // back-to-back with two stop bits: second start accepted in the done cycle
    run_frame(3, 8'h55, 0, 1'b0, 2, 1'b0, 45, 8'hAA);
    run_frame(3, 8'hAA, 0, 1'b0, 2, 1'b1, -1, 8'h00);
    repeat (3) begin
      @(negedge clk);
      chk_idle(3, "after_b2b");
    end

    // reset mid-frame at cycle 15 (data bit 2 of 00 -> line low)
    @(negedge clk);
    start_tx[0] = 1'b1;
    data_in[0]  = 8'h00;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      start_tx[0] = 1'b0;
    end
    chk("midreset line low c15", tx_serial[0], 1'b0);
    chk("midreset active c15", tx_active[0], 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk_idle(0, "midreset_async");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk_idle(0, "after_midreset");
    end
    run_frame(0, 8'h81, 0, 1'b0, 1, 1'b0, -1, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
